// File: rtl/bcd2bin_seq.sv
// bcd2bin_seq: sequential BCD-to-binary converter using reverse double-dabble.
// Each CONV cycle shifts {bcd_reg, mag_reg} right one bit and then subtracts 3
// from every BCD digit that has reached 8 or more. After BIN_W shifts, mag_reg
// holds the unsigned magnitude, which is then signed and range-checked.
// Optional build macro: SATURATE_EN. When defined, an overflowing result clamps
// to the signed limits. When undefined, the result is the two's-complement wrap.
module bcd2bin_seq #(
    parameter int BIN_W = 10,
    parameter int NDIG  = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [4*NDIG-1:0]   bcd,
    input  logic                neg,
    output logic                busy,
    output logic                done,
    output logic [BIN_W-1:0]    bin,
    output logic                overflow,
    output logic                bad_digit
);

    localparam int BCD_W = 4 * NDIG;
    localparam int CNT_W = $clog2(BIN_W + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CONV = 2'd1;
    localparam logic [1:0] S_FIN  = 2'd2;

    // Largest positive magnitude, and largest negative magnitude (2^(BIN_W-1)).
    localparam logic [BIN_W-1:0] POS_MAX = {1'b0, {(BIN_W-1){1'b1}}};
    localparam logic [BIN_W-1:0] NEG_MAX = {1'b1, {(BIN_W-1){1'b0}}};

    logic [1:0]       state_reg;
    logic [BCD_W-1:0] bcd_reg;
    logic [BIN_W-1:0] mag_reg;
    logic             neg_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             busy_reg;
    logic             done_reg;
    logic [BIN_W-1:0] bin_reg;
    logic             ovf_reg;
    logic             bad_reg;

    // Per-digit range check on the live input, and the shift/adjust datapath.
    logic [NDIG-1:0]  digit_bad;
    logic [BCD_W-1:0] shift_bcd;
    logic [BIN_W-1:0] shift_mag;
    logic [BCD_W-1:0] bcd_next;

    assign shift_bcd = {1'b0, bcd_reg[BCD_W-1:1]};
    assign shift_mag = {bcd_reg[0], mag_reg[BIN_W-1:1]};

    generate
        for (genvar gi = 0; gi < NDIG; gi++) begin : g_digit
            logic [3:0] in_digit;
            logic [3:0] sh_digit;
            assign in_digit      = bcd[4*gi +: 4];
            assign digit_bad[gi] = (in_digit > 4'd9);
            assign sh_digit      = shift_bcd[4*gi +: 4];
            // A digit that received a carried-in 1 at its top bit must lose 3
            // (half of the 6 skipped between 9 and 16 in the doubled domain).
            assign bcd_next[4*gi +: 4] = (sh_digit >= 4'd8) ? (sh_digit - 4'd3) : sh_digit;
        end
    endgenerate

    // Final sign application, overflow detection and optional clamping.
    logic             ovf_fin;
    logic [BIN_W-1:0] wrap_val;
    logic [BIN_W-1:0] result_fin;

    assign ovf_fin  = neg_reg ? (mag_reg > NEG_MAX) : (mag_reg > POS_MAX);
    assign wrap_val = neg_reg ? ('0 - mag_reg) : mag_reg;

`ifdef SATURATE_EN
    assign result_fin = ovf_fin ? (neg_reg ? NEG_MAX : POS_MAX) : wrap_val;
`else
    assign result_fin = wrap_val;
`endif

    // Control FSM plus shift registers and result/flag registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= S_IDLE;
            bcd_reg   <= '0;
            mag_reg   <= '0;
            neg_reg   <= 1'b0;
            cnt_reg   <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            bin_reg   <= '0;
            ovf_reg   <= 1'b0;
            bad_reg   <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        bcd_reg <= bcd;
                        neg_reg <= neg;
                        mag_reg <= '0;
                        ovf_reg <= 1'b0;
                        if (|digit_bad) begin
                            // Invalid input is reported immediately without converting.
                            bin_reg  <= '0;
                            bad_reg  <= 1'b1;
                            done_reg <= 1'b1;
                        end else begin
                            bad_reg   <= 1'b0;
                            busy_reg  <= 1'b1;
                            cnt_reg   <= '0;
                            state_reg <= S_CONV;
                        end
                    end
                end
                S_CONV: begin
                    bcd_reg <= bcd_next;
                    mag_reg <= shift_mag;
                    cnt_reg <= cnt_reg + 1'b1;
                    if (cnt_reg == CNT_W'(BIN_W - 1)) begin
                        state_reg <= S_FIN;
                    end
                end
                S_FIN: begin
                    bin_reg   <= result_fin;
                    ovf_reg   <= ovf_fin;
                    done_reg  <= 1'b1;
                    busy_reg  <= 1'b0;
                    state_reg <= S_IDLE;
                end
                default: begin
                    state_reg <= S_IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = busy_reg;
    assign done      = done_reg;
    assign bin       = bin_reg;
    assign overflow  = ovf_reg;
    assign bad_digit = bad_reg;

endmodule

// File: tb/tb_bcd2bin_seq.sv
// tb_bcd2bin_seq: directed-vector bench for bcd2bin_seq (BIN_W=10, NDIG=3).
// Expected values are hand-computed; overflow cases follow SATURATE_EN.
module tb_bcd2bin_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [11:0] bcd;
    logic        neg;
    logic        busy;
    logic        done;
    logic [9:0]  bin;
    logic        overflow;
    logic        bad_digit;

    int n_checks = 0;
    int n_errors = 0;

    bcd2bin_seq #(.BIN_W(10), .NDIG(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .bcd       (bcd),
        .neg       (neg),
        .busy      (busy),
        .done      (done),
        .bin       (bin),
        .overflow  (overflow),
        .bad_digit (bad_digit)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Start one conversion and wait for done. Latency counts cycles from the
    // cycle start is presented (1) up to the cycle done is seen.
    task automatic convert(input string tag, input logic [11:0] b, input logic n,
                           input logic [9:0] exp_bin, input logic exp_ovf,
                           input logic exp_bad, input int exp_lat);
        int   lat;
        logic seen_busy;
        @(negedge clk);
        bcd = b; neg = n; start = 1'b1;
        lat = 0; seen_busy = 1'b0;
        do begin
            @(posedge clk); #1;
            lat++;
            if (lat == 1) begin
                // Inputs scrambled after acceptance: the latched copy must be used.
                start = 1'b0;
                bcd   = 12'h999 - b;
                neg   = ~n;
            end
            if (busy) seen_busy = 1'b1;
        end while (!done && lat < 40);
        check({tag, " latency"}, lat, exp_lat);
        check({tag, " bin"}, bin, exp_bin);
        check({tag, " overflow"}, overflow, exp_ovf);
        check({tag, " bad_digit"}, bad_digit, exp_bad);
        check({tag, " busy at done"}, busy, 0);
        check({tag, " busy seen"}, seen_busy, !exp_bad);
        $display("conv %s: bcd=%03h neg=%0b -> bin=%03h ovf=%0b bad=%0b lat=%0d",
                 tag, b, n, bin, overflow, bad_digit, lat);
        @(posedge clk); #1;
        check({tag, " done pulse width"}, done, 0);
    endtask

    initial begin
        int   cyc;
        int   d1;
        int   d2;
        logic seen_done;

        reset = 1'b1; start = 1'b0; bcd = '0; neg = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset bin", bin, 0);
        check("reset overflow", overflow, 0);
        check("reset bad_digit", bad_digit, 0);

        convert("pos437", 12'h437, 1'b0, 10'h1B5, 1'b0, 1'b0, 12);
        convert("neg500", 12'h500, 1'b1, 10'h20C, 1'b0, 1'b0, 12);
        convert("neg512", 12'h512, 1'b1, 10'h200, 1'b0, 1'b0, 12);
        convert("pos511", 12'h511, 1'b0, 10'h1FF, 1'b0, 1'b0, 12);
`ifdef SATURATE_EN
        convert("pos999", 12'h999, 1'b0, 10'h1FF, 1'b1, 1'b0, 12);
        convert("neg999", 12'h999, 1'b1, 10'h200, 1'b1, 1'b0, 12);
        convert("pos512", 12'h512, 1'b0, 10'h1FF, 1'b1, 1'b0, 12);
        convert("neg513", 12'h513, 1'b1, 10'h200, 1'b1, 1'b0, 12);
`else
        convert("pos999", 12'h999, 1'b0, 10'h3E7, 1'b1, 1'b0, 12);
        convert("neg999", 12'h999, 1'b1, 10'h019, 1'b1, 1'b0, 12);
        convert("pos512", 12'h512, 1'b0, 10'h200, 1'b1, 1'b0, 12);
        convert("neg513", 12'h513, 1'b1, 10'h1FF, 1'b1, 1'b0, 12);
`endif
        convert("pos042", 12'h042, 1'b0, 10'h02A, 1'b0, 1'b0, 12);
        convert("bad4A2", 12'h4A2, 1'b0, 10'h000, 1'b0, 1'b1, 1);
        convert("bad09F", 12'h09F, 1'b1, 10'h000, 1'b0, 1'b1, 1);
        convert("neg123", 12'h123, 1'b1, 10'h385, 1'b0, 1'b0, 12);

        // Back-to-back: start held high, second start accepted on the done cycle.
        @(negedge clk);
        bcd = 12'h063; neg = 1'b0; start = 1'b1;
        cyc = 0; d1 = -1; d2 = -1;
        while (d2 < 0 && cyc < 60) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == 1) bcd = 12'h127;
            if (done) begin
                if (d1 < 0) begin
                    d1 = cyc;
                    check("b2b first bin", bin, 10'd63);
                    $display("conv b2b1: bin=%03h at cycle %0d", bin, cyc);
                end else begin
                    d2 = cyc;
                    start = 1'b0;
                    check("b2b second bin", bin, 10'd127);
                    $display("conv b2b2: bin=%03h at cycle %0d", bin, cyc);
                end
            end
        end
        start = 1'b0;
        check("b2b first done cycle", d1, 12);
        check("b2b done spacing", d2 - d1, 12);

        // Abort: start, an ignored start while busy, then reset mid-conversion.
        @(negedge clk);
        bcd = 12'h437; neg = 1'b0; start = 1'b1;
        seen_done = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            if (done) seen_done = 1'b1;
        end
        check("abort busy before reset", busy, 1);
        start = 1'b1; bcd = 12'h111;
        @(posedge clk); #1;
        if (done) seen_done = 1'b1;
        start = 1'b0; reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("abort busy", busy, 0);
        check("abort done", done, 0);
        check("abort bin", bin, 0);
        check("abort overflow", overflow, 0);
        check("abort bad_digit", bad_digit, 0);
        repeat (15) begin
            @(posedge clk); #1;
            if (done) seen_done = 1'b1;
        end
        check("abort no done", seen_done, 0);
        $display("conv abort: reset mid-conversion, bin=%03h busy=%0b", bin, busy);

        convert("negzero", 12'h000, 1'b1, 10'h000, 1'b0, 1'b0, 12);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
